// File: rtl/mem_stage_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the mem_stage_ls
// load/store stage.
package mem_stage_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic [3:0] nbytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store byte-enables and lane replication, and
// load data extraction with sign/zero extension.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter  int DW = 32,
    localparam int NB = DW / 8,
    localparam int OW = $clog2(NB)
) (
    input  logic [1:0]    st_size,
    input  logic [OW-1:0] st_off,
    input  logic [DW-1:0] st_wdata,
    output logic [NB-1:0] st_be,
    output logic [DW-1:0] st_wdata_rep,
    input  logic [1:0]    ld_size,
    input  logic [OW-1:0] ld_off,
    input  logic          ld_unsigned,
    input  logic [DW-1:0] ld_rdata,
    output logic [DW-1:0] ld_data
);

    logic [DW-1:0] shifted_s;
    logic [DW-1:0] mask_s;
    logic          sign_s;

    // Byte enables and write-data replication across all lanes
    always_comb begin
        st_be        = NB'(byte_mask(st_size, 3'(st_off)));
        st_wdata_rep = {DW{1'b0}};
        for (int i = 0; i < NB; i++) begin
            case (st_size)
                SZ_B:    st_wdata_rep[8*i +: 8] = st_wdata[7:0];
                SZ_H:    st_wdata_rep[8*i +: 8] = st_wdata[8*(i%2) +: 8];
                SZ_W:    st_wdata_rep[8*i +: 8] = st_wdata[8*(i%4) +: 8];
                default: st_wdata_rep[8*i +: 8] = st_wdata[8*i +: 8];
            endcase
        end
    end

    // Shift the addressed lanes down, mask to size, then extend
    always_comb begin
        shifted_s = ld_rdata >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B: begin
                mask_s = DW'(8'hFF);
                sign_s = shifted_s[7];
            end
            SZ_H: begin
                mask_s = DW'(16'hFFFF);
                sign_s = shifted_s[15];
            end
            SZ_W: begin
                mask_s = DW'(32'hFFFF_FFFF);
                sign_s = shifted_s[31];
            end
            default: begin
                mask_s = {DW{1'b1}};
                sign_s = 1'b0;
            end
        endcase
        if (ld_unsigned) begin
            ld_data = shifted_s & mask_s;
        end else begin
            ld_data = (shifted_s & mask_s) | (sign_s ? ~mask_s : {DW{1'b0}});
        end
    end

endmodule

// File: rtl/mem_stage_ls.sv
// Memory-access pipeline stage between EX and WB over a req/gnt/rvalid bus.
// Build option MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them.
module mem_stage_ls
    import mem_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int RW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [AW-1:0]   ex_addr,
    input  logic [DW-1:0]   ex_wdata,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [1:0]      ex_size,
    input  logic            ex_unsigned,
    input  logic [RW-1:0]   ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_to_reg,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW/8-1:0] mem_be,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            wb_valid,
    output logic [DW-1:0]   wb_data,
    output logic [AW-1:0]   wb_result,
    output logic [RW-1:0]   wb_rd,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic            misalign_err
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

    state_e        state_r;
    state_e        state_nxt_s;

    logic          accept_s;
    logic          is_mem_s;
    logic          accept_mem_s;
    logic          size_illegal_s;
    logic          off_bad_s;
    logic          trap_s;
    logic [1:0]    eff_size_s;
    logic [OW-1:0] raw_off_s;
    logic [OW-1:0] align_mask_s;
    logic [OW-1:0] off_s;
    logic [NB-1:0] be_s;
    logic [DW-1:0] wdata_rep_s;
    logic [DW-1:0] ld_data_s;

    logic [1:0]    size_r;
    logic [OW-1:0] off_r;
    logic          unsigned_r;
    logic          load_r;
    logic [AW-1:0] addr_r;
    logic [RW-1:0] rd_r;
    logic          reg_write_r;
    logic          mem_to_reg_r;

    logic          mem_req_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [NB-1:0] mem_be_r;
    logic [DW-1:0] mem_wdata_r;
    logic          wb_valid_r;
    logic [DW-1:0] wb_data_r;
    logic [AW-1:0] wb_result_r;
    logic [RW-1:0] wb_rd_r;
    logic          wb_reg_write_r;
    logic          wb_mem_to_reg_r;

    assign ex_ready     = (state_r == IDLE);
    assign accept_s     = ex_valid && (state_r == IDLE);
    assign is_mem_s     = ex_mem_read || ex_mem_write;
    assign accept_mem_s = accept_s && is_mem_s && !trap_s;

    // Doubleword on a 32-bit bus degrades to a word access
    always_comb begin
        size_illegal_s = (DW == 32) && (ex_size == SZ_D);
        if (size_illegal_s) begin
            eff_size_s = SZ_W;
        end else begin
            eff_size_s = ex_size;
        end
        raw_off_s    = ex_addr[OW-1:0];
        align_mask_s = OW'(nbytes(eff_size_s) - 4'd1);
        off_bad_s    = (raw_off_s & align_mask_s) != {OW{1'b0}};
        if (off_bad_s) begin
            off_s = {OW{1'b0}};
        end else begin
            off_s = raw_off_s;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_err_r;

    assign trap_s       = accept_s && is_mem_s && (off_bad_s || size_illegal_s);
    assign misalign_err = misalign_err_r;

    // One-cycle trap pulse alongside the WB completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err_r <= 1'b0;
        end else begin
            misalign_err_r <= trap_s;
        end
    end
`else
    assign trap_s       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    mem_lane_align #(.DW(DW)) u_lane (
        .st_size      (eff_size_s),
        .st_off       (off_s),
        .st_wdata     (ex_wdata),
        .st_be        (be_s),
        .st_wdata_rep (wdata_rep_s),
        .ld_size      (size_r),
        .ld_off       (off_r),
        .ld_unsigned  (unsigned_r),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_mem_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_nxt_s = load_r ? RESP : IDLE;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Latch the access and drive the request, held stable until granted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {AW{1'b0}};
            mem_be_r     <= {NB{1'b0}};
            mem_wdata_r  <= {DW{1'b0}};
            size_r       <= SZ_B;
            off_r        <= {OW{1'b0}};
            unsigned_r   <= 1'b0;
            load_r       <= 1'b0;
            addr_r       <= {AW{1'b0}};
            rd_r         <= {RW{1'b0}};
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
        end else begin
            mem_req_r <= (state_nxt_s == REQ);
            if (accept_mem_s) begin
                mem_we_r     <= !ex_mem_read;
                mem_addr_r   <= ex_addr & ~AW'(NB - 1);
                mem_be_r     <= be_s;
                mem_wdata_r  <= wdata_rep_s;
                size_r       <= eff_size_s;
                off_r        <= off_s;
                unsigned_r   <= ex_unsigned;
                load_r       <= ex_mem_read;
                addr_r       <= ex_addr;
                rd_r         <= ex_rd;
                reg_write_r  <= ex_reg_write;
                mem_to_reg_r <= ex_mem_to_reg;
            end else if (state_nxt_s != REQ) begin
                mem_we_r <= 1'b0;
            end
        end
    end

    // WB register: ALU/trap completions, store grants and load responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_r      <= 1'b0;
            wb_data_r       <= {DW{1'b0}};
            wb_result_r     <= {AW{1'b0}};
            wb_rd_r         <= {RW{1'b0}};
            wb_reg_write_r  <= 1'b0;
            wb_mem_to_reg_r <= 1'b0;
        end else begin
            wb_valid_r <= 1'b0;
            if (accept_s && (!is_mem_s || trap_s)) begin
                wb_valid_r      <= 1'b1;
                wb_data_r       <= {DW{1'b0}};
                wb_result_r     <= ex_addr;
                wb_rd_r         <= ex_rd;
                wb_reg_write_r  <= ex_reg_write && !trap_s;
                wb_mem_to_reg_r <= ex_mem_to_reg;
            end else if ((state_r == REQ) && mem_gnt && !load_r) begin
                wb_valid_r      <= 1'b1;
                wb_data_r       <= {DW{1'b0}};
                wb_result_r     <= addr_r;
                wb_rd_r         <= rd_r;
                wb_reg_write_r  <= reg_write_r;
                wb_mem_to_reg_r <= mem_to_reg_r;
            end else if ((state_r == RESP) && mem_rvalid) begin
                wb_valid_r      <= 1'b1;
                wb_data_r       <= ld_data_s;
                wb_result_r     <= addr_r;
                wb_rd_r         <= rd_r;
                wb_reg_write_r  <= reg_write_r;
                wb_mem_to_reg_r <= mem_to_reg_r;
            end
        end
    end

    assign mem_req       = mem_req_r;
    assign mem_we        = mem_we_r;
    assign mem_addr      = mem_addr_r;
    assign mem_be        = mem_be_r;
    assign mem_wdata     = mem_wdata_r;
    assign wb_valid      = wb_valid_r;
    assign wb_data       = wb_data_r;
    assign wb_result     = wb_result_r;
    assign wb_rd         = wb_rd_r;
    assign wb_reg_write  = wb_reg_write_r;
    assign wb_mem_to_reg = wb_mem_to_reg_r;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed self-checking bench for mem_stage_ls (32-bit and 64-bit instances).
module tb_mem_stage_ls;

    localparam int AW = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 32-bit instance
    logic          ex_valid, ex_ready, ex_mem_read, ex_mem_write, ex_unsigned;
    logic          ex_reg_write, ex_mem_to_reg;
    logic [AW-1:0] ex_addr;
    logic [31:0]   ex_wdata;
    logic [1:0]    ex_size;
    logic [RW-1:0] ex_rd;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          wb_valid, wb_reg_write, wb_mem_to_reg, misalign_err;
    logic [31:0]   wb_data;
    logic [AW-1:0] wb_result;
    logic [RW-1:0] wb_rd;

    // 64-bit instance
    logic          ex_valid_64, ex_ready_64, ex_mem_read_64, ex_unsigned_64;
    logic [AW-1:0] ex_addr_64;
    logic [1:0]    ex_size_64;
    logic          mem_req_64, mem_we_64, mem_gnt_64, mem_rvalid_64;
    logic [AW-1:0] mem_addr_64;
    logic [7:0]    mem_be_64;
    logic [63:0]   mem_wdata_64, mem_rdata_64;
    logic          wb_valid_64, wb_reg_write_64, wb_mem_to_reg_64, misalign_err_64;
    logic [63:0]   wb_data_64;
    logic [AW-1:0] wb_result_64;
    logic [RW-1:0] wb_rd_64;

    mem_stage_ls #(.DW(32), .AW(AW), .RW(RW)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_result(wb_result), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .misalign_err(misalign_err)
    );

    mem_stage_ls #(.DW(64), .AW(AW), .RW(RW)) dut64 (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid_64), .ex_ready(ex_ready_64), .ex_addr(ex_addr_64),
        .ex_wdata(64'h0), .ex_mem_read(ex_mem_read_64), .ex_mem_write(1'b0),
        .ex_size(ex_size_64), .ex_unsigned(ex_unsigned_64), .ex_rd(5'd12),
        .ex_reg_write(1'b1), .ex_mem_to_reg(1'b1),
        .mem_req(mem_req_64), .mem_we(mem_we_64), .mem_addr(mem_addr_64), .mem_be(mem_be_64),
        .mem_wdata(mem_wdata_64), .mem_gnt(mem_gnt_64), .mem_rvalid(mem_rvalid_64),
        .mem_rdata(mem_rdata_64),
        .wb_valid(wb_valid_64), .wb_data(wb_data_64), .wb_result(wb_result_64), .wb_rd(wb_rd_64),
        .wb_reg_write(wb_reg_write_64), .wb_mem_to_reg(wb_mem_to_reg_64),
        .misalign_err(misalign_err_64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_unsigned = 1'b0;
        ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
        ex_size = 2'b00; ex_rd = 5'd0;
    endtask

    task automatic test_reset();
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
        total++; if ({mem_req, mem_we, wb_valid, wb_reg_write, wb_mem_to_reg, misalign_err} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=000000", {mem_req, mem_we, wb_valid, wb_reg_write, wb_mem_to_reg, misalign_err});
        end
        total++; if (mem_be !== 4'h0) begin bad++; $display("FAIL reset_mem_be got=%h exp=0", mem_be); end
        total++; if ({wb_data, wb_result, wb_rd} !== 69'h0) begin
            bad++; $display("FAIL reset_wb_fields got=%h/%h/%h exp=0", wb_data, wb_result, wb_rd);
        end
        total++; if ({mem_req_64, wb_valid_64, mem_be_64} !== 10'h0) begin
            bad++; $display("FAIL reset_dw64 got=%b/%b/%h exp=0", mem_req_64, wb_valid_64, mem_be_64);
        end
    endtask

    task automatic do_store(input logic [AW-1:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                            input logic [AW-1:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input string name);
        mem_gnt = 1'b1;
        ex_valid = 1'b1; ex_mem_write = 1'b1; ex_mem_read = 1'b0; ex_size = size; ex_addr = addr;
        ex_wdata = wdata; ex_rd = 5'd9; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0; ex_unsigned = 1'b0;
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b exp=1", name, ex_ready); end
        step(); clear_ex();
        total++; if ({mem_req, mem_we, ex_ready, wb_valid} !== 4'b1100) begin
            bad++; $display("FAIL %s_req_ctrl got=%b exp=1100", name, {mem_req, mem_we, ex_ready, wb_valid});
        end
        total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL %s_addr got=%h exp=%h", name, mem_addr, exp_addr); end
        total++; if (mem_be !== exp_be) begin bad++; $display("FAIL %s_be got=%b exp=%b", name, mem_be, exp_be); end
        total++; if (mem_wdata !== exp_wdata) begin bad++; $display("FAIL %s_wdata got=%h exp=%h", name, mem_wdata, exp_wdata); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL %s_misalign got=%b exp=0", name, misalign_err); end
        step();
        total++; if ({wb_valid, mem_req, wb_reg_write, ex_ready} !== 4'b1001) begin
            bad++; $display("FAIL %s_wb_ctrl got=%b exp=1001", name, {wb_valid, mem_req, wb_reg_write, ex_ready});
        end
        total++; if (wb_result !== addr || wb_rd !== 5'd9) begin
            bad++; $display("FAIL %s_wb_fields got=%h/%0d exp=%h/9", name, wb_result, wb_rd, addr);
        end
        step();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL %s_pulse got=%b exp=0", name, wb_valid); end
        mem_gnt = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] rdata, input logic [AW-1:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data,
                           input int gnt_wait, input string name);
        mem_gnt = (gnt_wait == 0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_addr = addr; ex_size = size;
        ex_unsigned = uns; ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1; ex_wdata = 32'h5555_5555;
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b exp=1", name, ex_ready); end
        step(); clear_ex();
        total++; if ({mem_req, mem_we, ex_ready, wb_valid, misalign_err} !== 5'b10000) begin
            bad++; $display("FAIL %s_req_ctrl got=%b exp=10000", name, {mem_req, mem_we, ex_ready, wb_valid, misalign_err});
        end
        total++; if (mem_addr !== exp_addr || mem_be !== exp_be) begin
            bad++; $display("FAIL %s_addr_be got=%h/%b exp=%h/%b", name, mem_addr, mem_be, exp_addr, exp_be);
        end
        for (int k = 0; k < gnt_wait; k++) begin
            step();
            total++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr || mem_be !== exp_be
                || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
                bad++; $display("FAIL %s_stall%0d got req=%b we=%b addr=%h be=%b rdy=%b wbv=%b exp req=1 we=0 addr=%h be=%b rdy=0 wbv=0",
                                name, k, mem_req, mem_we, mem_addr, mem_be, ex_ready, wb_valid, exp_addr, exp_be);
            end
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rdata = rdata; mem_rvalid = 1'b1;
        total++; if ({mem_req, ex_ready, wb_valid} !== 3'b000) begin
            bad++; $display("FAIL %s_resp_ctrl got=%b exp=000", name, {mem_req, ex_ready, wb_valid});
        end
        step();
        mem_rvalid = 1'b0;
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL %s_wb_valid got=%b exp=1", name, wb_valid); end
        total++; if (wb_data !== exp_data) begin bad++; $display("FAIL %s_wb_data got=%h exp=%h", name, wb_data, exp_data); end
        total++; if (wb_rd !== 5'd7 || wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b1 || wb_result !== addr) begin
            bad++; $display("FAIL %s_wb_fields got=%0d/%b/%b/%h exp=7/1/1/%h", name, wb_rd, wb_reg_write, wb_mem_to_reg, wb_result, addr);
        end
        step();
        total++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            bad++; $display("FAIL %s_pulse got=%b/%b exp=0/1", name, wb_valid, ex_ready);
        end
    endtask

    task automatic test_store_byte();
        do_store(32'h103, 2'b00, 32'h1234_56AB, 32'h100, 4'b1000, 32'hABAB_ABAB, "st_byte");
    endtask

    task automatic test_load_byte();
        do_load(32'h102, 2'b00, 1'b0, 32'h0080_0000, 32'h100, 4'b0100, 32'hFFFF_FF80, 0, "ld_b_signed");
        do_load(32'h102, 2'b00, 1'b1, 32'h0080_0000, 32'h100, 4'b0100, 32'h0000_0080, 0, "ld_b_unsigned");
    endtask

    task automatic test_gnt_stall();
        do_load(32'h2, 2'b01, 1'b0, 32'hBEEF_1234, 32'h0, 4'b1100, 32'hFFFF_BEEF, 4, "ld_h_stall");
    endtask

    task automatic test_dw64();
        logic [63:0] exp;
        for (int t = 0; t < 2; t++) begin
            mem_gnt_64 = 1'b1;
            ex_valid_64 = 1'b1; ex_mem_read_64 = 1'b1; ex_unsigned_64 = 1'b0;
            ex_addr_64 = (t == 0) ? 32'h8 : 32'hC;
            ex_size_64 = (t == 0) ? 2'b11 : 2'b10;
            step();
            ex_valid_64 = 1'b0; ex_mem_read_64 = 1'b0;
            total++; if (mem_req_64 !== 1'b1 || mem_addr_64 !== 32'h8 || mem_be_64 !== ((t == 0) ? 8'hFF : 8'hF0)) begin
                bad++; $display("FAIL dw64_req%0d got=%b/%h/%h", t, mem_req_64, mem_addr_64, mem_be_64);
            end
            step();
            mem_gnt_64 = 1'b0; mem_rvalid_64 = 1'b1;
            mem_rdata_64 = (t == 0) ? 64'h1122_3344_5566_7788 : 64'h8000_0001_0000_0000;
            step();
            mem_rvalid_64 = 1'b0;
            exp = (t == 0) ? 64'h1122_3344_5566_7788 : 64'hFFFF_FFFF_8000_0001;
            total++; if (wb_valid_64 !== 1'b1 || wb_data_64 !== exp) begin
                bad++; $display("FAIL dw64_data%0d got=%b/%h exp=1/%h", t, wb_valid_64, wb_data_64, exp);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        mem_gnt = 1'b1; mem_rvalid = 1'b0;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_addr = 32'h40; ex_size = 2'b10; ex_rd = 5'd6; ex_reg_write = 1'b1;
        step(); clear_ex();
        step(); mem_gnt = 1'b0;
        total++; if (mem_req !== 1'b0 || ex_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_in_resp got=%b/%b exp=0/0", mem_req, ex_ready);
        end
        reset = 1'b1;
        #1;
        total++; if (ex_ready !== 1'b1 || mem_req !== 1'b0 || wb_data !== 32'h0) begin
            bad++; $display("FAIL rst_mid_async got=%b/%b/%h exp=1/0/0", ex_ready, mem_req, wb_data);
        end
        step(); reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step(); mem_rvalid = 1'b0;
        total++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_no_wb got=%b/%b exp=0/1", wb_valid, ex_ready);
        end
        ex_valid = 1'b1; ex_addr = 32'h1234; ex_rd = 5'd3; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b0;
        step(); clear_ex();
        total++; if ({wb_valid, mem_req, ex_ready, wb_reg_write, wb_mem_to_reg} !== 5'b10110) begin
            bad++; $display("FAIL rst_mid_alu_ctrl got=%b exp=10110", {wb_valid, mem_req, ex_ready, wb_reg_write, wb_mem_to_reg});
        end
        total++; if (wb_data !== 32'h0 || wb_result !== 32'h1234 || wb_rd !== 5'd3) begin
            bad++; $display("FAIL rst_mid_alu_fields got=%h/%h/%0d exp=0/1234/3", wb_data, wb_result, wb_rd);
        end
        step();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_alu_pulse got=%b exp=0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        ex_valid = 1'b1; ex_addr = 32'h10; ex_rd = 5'd1; ex_reg_write = 1'b1;
        step();
        total++; if (wb_valid !== 1'b1 || wb_result !== 32'h10 || wb_rd !== 5'd1) begin
            bad++; $display("FAIL b2b_first got=%b/%h/%0d exp=1/10/1", wb_valid, wb_result, wb_rd);
        end
        ex_addr = 32'h20; ex_rd = 5'd2;
        step(); clear_ex();
        total++; if (wb_valid !== 1'b1 || wb_result !== 32'h20 || wb_rd !== 5'd2) begin
            bad++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/20/2", wb_valid, wb_result, wb_rd);
        end
        step();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", wb_valid); end
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_addr = 32'h102; ex_size = 2'b10; ex_rd = 5'd4; ex_reg_write = 1'b1;
        step(); clear_ex();
        total++; if ({mem_req, misalign_err, wb_valid, wb_reg_write, ex_ready} !== 5'b01101) begin
            bad++; $display("FAIL trap_pulse got=%b exp=01101", {mem_req, misalign_err, wb_valid, wb_reg_write, ex_ready});
        end
        step();
        total++; if ({mem_req, misalign_err, wb_valid} !== 3'b000) begin
            bad++; $display("FAIL trap_end got=%b exp=000", {mem_req, misalign_err, wb_valid});
        end
`else
        do_load(32'h102, 2'b10, 1'b0, 32'h1122_3344, 32'h100, 4'b1111, 32'h1122_3344, 0, "ld_w_misaligned");
        do_store(32'h1, 2'b01, 32'h9999_CDEF, 32'h0, 4'b0011, 32'hCDEF_CDEF, "st_h_misaligned");
        do_store(32'h4, 2'b11, 32'hA1B2_C3D4, 32'h4, 4'b1111, 32'hA1B2_C3D4, "st_d_on_dw32");
`endif
    endtask

    initial begin
        reset = 1'b1;
        clear_ex();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        ex_valid_64 = 1'b0; ex_mem_read_64 = 1'b0; ex_unsigned_64 = 1'b0; ex_addr_64 = 32'h0;
        ex_size_64 = 2'b00; mem_gnt_64 = 1'b0; mem_rvalid_64 = 1'b0; mem_rdata_64 = 64'h0;
        step(); step();
        test_reset();
        reset = 1'b0;
        step();
        test_store_byte();
        test_load_byte();
        test_gnt_stall();
        test_dw64();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
